// File: rtl/argmax_4_16.sv
// argmax_4_16: streaming argmax over M signed words per vector, one {index, value} result per vector.
module argmax_4_16 #(
  parameter int M    = 4,
  parameter int T    = 16,
  parameter int logM = $clog2(M)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [logM-1:0]     idx_out,
  output logic signed [T-1:0] max_out
);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state, state_n;
  logic [logM-1:0] cnt, best_idx;
  logic signed [T-1:0] best_val;
  logic acc, last, gt;
  assign m_valid = state == HOLD;
  always_comb begin
    s_ready = !reset && (!m_valid || m_ready);
    acc     = s_valid && s_ready;
    last    = cnt == logM'(M-1);
    gt      = data_in > best_val;
    state_n = (acc && last) ? HOLD : (state == HOLD && m_ready) ? COLLECT : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COLLECT;
      cnt      <= '0;
      best_val <= '0;
      best_idx <= '0;
      idx_out  <= '0;
      max_out  <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        cnt <= last ? '0 : cnt + logM'(1);
        if (cnt == '0) begin
          best_val <= data_in;
          best_idx <= '0;
        end else if (gt) begin
          best_val <= data_in;
          best_idx <= cnt;
        end
        if (last) begin
          max_out <= gt ? data_in : best_val;
          idx_out <= gt ? cnt : best_idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_argmax_4_16.sv
// tb_argmax_4_16: directed and randomized checks of argmax_4_16 against a queue-based argmax model.
module tb_argmax_4_16;
  logic clk = 0, reset, s_valid, s_ready, m_valid, m_ready;
  logic signed [15:0] data_in, max_out;
  logic [1:0] idx_out;
  int checks = 0, errors = 0, completed = 0, results = 0;
  typedef struct {logic [1:0] i; logic signed [15:0] v;} res_t;
  logic signed [15:0] words[$];
  res_t exp_q[$];

  argmax_4_16 dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready), .idx_out(idx_out), .max_out(max_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic res_t ref_argmax(input logic signed [15:0] w[$]);
    res_t r;
    r.i = 0;
    r.v = w[0];
    for (int k = 1; k < w.size(); k++)
      if (w[k] > r.v) begin
        r.i = 2'(k);
        r.v = w[k];
      end
    return r;
  endfunction

  // Scoreboard: inputs are driven at negedge, so negedge+2 sees exactly what the next posedge will take.
  always @(negedge clk) begin
    res_t r;
    #2;
    if (reset) words.delete();
    else begin
      if (m_valid && m_ready) begin
        results++;
        if (exp_q.size() == 0) check("extra_result", 1, 0);
        else begin
          r = exp_q.pop_front();
          check("sb_idx", idx_out, r.i);
          check("sb_max", max_out, r.v);
        end
      end
      if (s_valid && s_ready) begin
        words.push_back(data_in);
        if (words.size() == 4) begin
          exp_q.push_back(ref_argmax(words));
          words.delete();
          completed++;
        end
      end
    end
  end

  task automatic push(input logic signed [15:0] d);
    s_valid = 1;
    data_in = d;
    @(negedge clk);
  endtask

  task automatic expect_res(input string tag, input logic [1:0] i, input logic signed [15:0] v);
    #1;
    check({tag, "_valid"}, m_valid, 1);
    check({tag, "_idx"}, idx_out, i);
    check({tag, "_max"}, max_out, v);
  endtask

  initial begin
    logic signed [15:0] b2b[8] = '{4, 3, 2, 1, 0, 9, 0, 0};
    int cyc;
    reset = 1; s_valid = 1; m_ready = 1; data_in = 5;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_idx", idx_out, 0);
    check("rst_max", max_out, 0);
    check("rst_s_ready", s_ready, 0);
    reset = 0; s_valid = 0;
    @(negedge clk);

    push(87); push(0); push(200); push(5);
    s_valid = 0;
    expect_res("basic", 2, 200);
    @(negedge clk); #1;
    check("basic_drop", m_valid, 0);

    push(10); push(10); push(3); push(10);
    s_valid = 0;
    expect_res("tie", 0, 10);
    @(negedge clk);
    push(-5); push(-3); push(-9); push(-4);
    s_valid = 0;
    expect_res("neg", 1, -3);
    @(negedge clk);

    m_ready = 0;
    push(1); push(2); push(3); push(4);
    data_in = 99;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      expect_res("hold", 3, 4);
      check("hold_s_ready", s_ready, 0);
    end
    @(negedge clk);
    m_ready = 1; s_valid = 0;
    #1;
    check("release_s_ready", s_ready, 1);
    @(negedge clk); #1;
    check("release_drop", m_valid, 0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      s_valid = 1; data_in = b2b[i];
      #1;
      check("b2b_s_ready", s_ready, 1);
      check("b2b_valid", m_valid, i == 4);
      if (i == 4) begin
        check("b2b0_idx", idx_out, 0);
        check("b2b0_max", max_out, 4);
      end
      @(negedge clk);
    end
    s_valid = 0;
    expect_res("b2b1", 1, 9);
    @(negedge clk);

    push(100); push(50);
    s_valid = 0; reset = 1;
    #1;
    check("midrst_s_ready", s_ready, 0);
    @(negedge clk);
    reset = 0;
    #1;
    check("midrst_valid", m_valid, 0);
    push(1); push(7); push(2); push(3);
    s_valid = 0;
    expect_res("midrst", 1, 7);
    @(negedge clk);
    check("directed_count", completed, 7);

    cyc = 0;
    while (completed < 1007 && cyc < 30000) begin
      s_valid = $urandom_range(0, 3) != 0;
      m_ready = $urandom_range(0, 1) != 0;
      data_in = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 3));
      @(negedge clk);
      cyc++;
    end
    check("rand_budget", cyc < 30000, 1);
    s_valid = 0; m_ready = 1;
    repeat (4) @(negedge clk);
    check("rand_completed", completed, 1007);
    check("results_seen", results, completed);
    check("none_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/argmax_4_16.md
# argmax_4_16

Classification stage placed directly downstream of the 4-output, 16-bit fully-connected layer. It consumes the layer's M-word output vector one word per handshake, tracks the running maximum, and emits one {index, value} result per vector on a valid/ready output port. It gives the network a single class decision per inference without buffering the whole vector.

## Interface
- M, default 4: words per vector (class count); M ≥ 2.
- T, default 16: word width, two's-complement signed.
- logM, default $clog2(M): width of index and word counter.

- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high; clock clk.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  block can accept a word this cycle.
- data_in  input  T  signed upstream word (layer ReLU output).
- m_valid  output  1  result valid.
- m_ready  input  1  downstream accepts result.
- idx_out  output  logM  index (0..M-1) of maximum word in the vector.
- max_out  output  T  signed value of that word.

## Operation
- Input handshake: word accepted when s_valid && s_ready at posedge. Output handshake: result consumed when m_valid && m_ready at posedge.
- Registers: cnt (logM bits, position of next word), best_val (T), best_idx (logM), idx_out, max_out, m_valid.
- States: COLLECT (m_valid=0) and HOLD (m_valid=1).
- s_ready = !reset && (!m_valid || m_ready), combinational. In HOLD, a word may be accepted in the same cycle the result is consumed; that word is element 0 of the next vector.
- Accepted word with cnt==0: best_val<=data_in, best_idx<=0 unconditionally.
- Accepted word with 0<cnt<M-1: if data_in > best_val (signed, strict), best_val<=data_in, best_idx<=cnt.
- Accepted word with cnt==M-1: final compare of data_in vs best_val (strict signed >); winner written to max_out/idx_out; m_valid<=1; cnt<=0.
- cnt increments on every accepted word, wraps M-1 -> 0. For M not a power of 2, wrap is explicit at M-1.
- Tie rule: lowest index wins (strict greater-than only replaces).
- No arithmetic beyond signed T-bit compare; no widening, no saturation.
- HOLD: idx_out, max_out, m_valid stable while m_ready=0. On m_ready=1, m_valid<=0 unless the same cycle's accepted word completes another vector (only possible with M=1, excluded).

## Timing
- Reset values: m_valid=0, idx_out=0, max_out=0, cnt=0, best_val=0, best_idx=0; s_ready=0 during reset cycle.
- Reset mid-vector: partial vector discarded; first word after reset is element 0.
- Latency: last word accepted at edge k -> m_valid=1 and outputs valid in cycle after edge k (1 cycle).
- Throughput: one vector per M cycles sustained when s_valid and m_ready held high; s_ready never drops in that case.
- Backpressure: m_valid && !m_ready forces s_ready=0; no words accepted, cnt frozen, until the cycle m_ready=1.
- s_valid=0 gaps mid-vector: state held indefinitely, no timeout.
- m_valid does not depend combinationally on m_ready; s_ready does (combinational path m_ready->s_ready is intended).

## Test plan
- Vector {87, 0, 200, 5}, m_ready=1 -> one cycle after 4th accept: m_valid=1, idx_out=2, max_out=200; m_valid low next cycle.
- Ties {10, 10, 3, 10} -> idx_out=0, max_out=10; negatives {-5, -3, -9, -4} -> idx_out=1, max_out=-3.
- Vector {1,2,3,4} with m_ready=0 for 3 cycles after m_valid -> idx_out=3/max_out=4 stable, s_ready=0 for those 3 cycles, s_valid words ignored; m_ready=1 -> s_ready=1 same cycle.
- Back-to-back vectors {4,3,2,1},{0,9,0,0} with s_valid=m_ready=1 continuously -> results (0,4) then (1,9), s_ready high every cycle, results 4 cycles apart.
- Reset asserted after 2 words {100,50}, then vector {1,7,2,3} -> single result idx_out=1, max_out=7; no result for the partial vector.
- Random vectors with random s_valid/m_ready stalls, 1000 vectors -> every result matches a software argmax (lowest-index ties), no result lost or duplicated.
